// File: rtl/switch_pkg.sv
// Shared types and defaults for the chiplet switch allocator.
// The per-output lock FSM encoding and ID widths live here.
package switch_pkg;

    localparam int SA_NUM_INPORTS  = 4;
    localparam int SA_NUM_OUTPORTS = 4;
    localparam int SA_NUM_VCS      = 2;

    localparam int PORT_ID_W = $clog2(SA_NUM_OUTPORTS);
    localparam int VC_ID_W   = $clog2(SA_NUM_VCS);

    typedef logic [PORT_ID_W-1:0] port_id_t;
    typedef logic [VC_ID_W-1:0]   vc_id_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } sa_state_e;

    // An index into n items needs at least one bit, even when n is 1.
    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/switch_allocator_rr_arbiter.sv
// Round-robin arbiter: picks the first set request at or above ptr,
// wrapping, and returns it as a one-hot grant plus an index.
module rr_arbiter
    import switch_pkg::*;
#(
    parameter  int N  = 4,
    localparam int IW = id_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] idx,
    output logic          valid
);

    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        // NOTE: every output gets a default before the search so that no
        // path through the loop leaves a value unassigned (no latches).
        gnt      = '0;
        idx      = '0;
        valid    = 1'b0;
        cand     = 0;
        cand_idx = '0;
        for (int k = 0; k < N; k++) begin
            cand     = (int'(ptr) + k) % N;
            cand_idx = IW'(cand);
            if (!valid && req[cand_idx]) begin
                valid         = 1'b1;
                gnt[cand_idx] = 1'b1;
                idx           = cand_idx;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// Per-output round-robin switch allocator with wormhole locking.
// Grants are combinational; lock owner, VC and round-robin pointer are registered.
module switch_allocator
    import switch_pkg::*;
#(
    parameter  int NUM_INPORTS  = SA_NUM_INPORTS,
    parameter  int NUM_OUTPORTS = SA_NUM_OUTPORTS,
    parameter  int NUM_VCS      = SA_NUM_VCS,
    localparam int IW           = id_width(NUM_INPORTS),
    localparam int OW           = id_width(NUM_OUTPORTS),
    localparam int VW           = id_width(NUM_VCS)
) (
    input  logic                                  clk,
    input  logic                                  n_rst,
    input  logic [NUM_INPORTS-1:0]                req,
    input  logic [NUM_INPORTS-1:0][OW-1:0]        req_outport,
    input  logic [NUM_INPORTS-1:0][VW-1:0]        req_vc,
    input  logic [NUM_INPORTS-1:0]                req_tail,
    input  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]  buffer_available,
    output logic [NUM_INPORTS-1:0]                grant,
    output logic [NUM_OUTPORTS-1:0]               xbar_valid,
    output logic [NUM_OUTPORTS-1:0][IW-1:0]       xbar_sel,
    output logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]  packet_sent
);

    sa_state_e     state_q    [NUM_OUTPORTS];
    sa_state_e     state_d    [NUM_OUTPORTS];
    logic [IW-1:0] owner_q    [NUM_OUTPORTS];
    logic [IW-1:0] owner_d    [NUM_OUTPORTS];
    logic [VW-1:0] owner_vc_q [NUM_OUTPORTS];
    logic [VW-1:0] owner_vc_d [NUM_OUTPORTS];
    logic [IW-1:0] rr_ptr_q   [NUM_OUTPORTS];
    logic [IW-1:0] rr_ptr_d   [NUM_OUTPORTS];

    logic [NUM_INPORTS-1:0] elig      [NUM_OUTPORTS];
    logic [NUM_INPORTS-1:0] arb_gnt   [NUM_OUTPORTS];
    logic [IW-1:0]          arb_idx   [NUM_OUTPORTS];
    logic                   arb_valid [NUM_OUTPORTS];

    logic                   out_valid [NUM_OUTPORTS];
    logic [IW-1:0]          out_sel   [NUM_OUTPORTS];
    logic [VW-1:0]          out_vc    [NUM_OUTPORTS];
    logic [NUM_INPORTS-1:0] gnt_any;

    // An out-of-range req_outport never equals a real output index.
    always_comb begin
        for (int o = 0; o < NUM_OUTPORTS; o++) begin
            for (int i = 0; i < NUM_INPORTS; i++) begin
                elig[o][i] = req[i]
                          && (int'(req_outport[i]) == o)
                          && buffer_available[o][req_vc[i]];
            end
        end
    end

    for (genvar o = 0; o < NUM_OUTPORTS; o++) begin : g_arb
        rr_arbiter #(
            .N (NUM_INPORTS)
        ) u_arb (
            .req   (elig[o]),
            .ptr   (rr_ptr_q[o]),
            .gnt   (arb_gnt[o]),
            .idx   (arb_idx[o]),
            .valid (arb_valid[o])
        );
    end

    always_comb begin
        gnt_any = '0;
        for (int o = 0; o < NUM_OUTPORTS; o++) begin
            state_d[o]    = state_q[o];
            owner_d[o]    = owner_q[o];
            owner_vc_d[o] = owner_vc_q[o];
            rr_ptr_d[o]   = rr_ptr_q[o];
            out_valid[o]  = 1'b0;
            out_sel[o]    = '0;
            out_vc[o]     = '0;

            unique case (state_q[o])
                IDLE: begin
                    if (arb_valid[o]) begin
                        out_valid[o] = 1'b1;
                        out_sel[o]   = arb_idx[o];
                        out_vc[o]    = req_vc[arb_idx[o]];
                        gnt_any      = gnt_any | arb_gnt[o];
                        if (!req_tail[arb_idx[o]]) begin
                            state_d[o]    = LOCKED;
                            owner_d[o]    = arb_idx[o];
                            owner_vc_d[o] = req_vc[arb_idx[o]];
                        end
                        rr_ptr_d[o] = (int'(arb_idx[o]) == NUM_INPORTS - 1)
                                    ? '0 : arb_idx[o] + IW'(1);
                    end
                end
                LOCKED: begin
                    // The owner keeps the output even while stalled; its own
                    // outport/VC fields are not consulted mid-packet.
                    if (req[owner_q[o]] && buffer_available[o][owner_vc_q[o]]) begin
                        out_valid[o]        = 1'b1;
                        out_sel[o]          = owner_q[o];
                        out_vc[o]           = owner_vc_q[o];
                        gnt_any[owner_q[o]] = 1'b1;
                        if (req_tail[owner_q[o]]) begin
                            state_d[o] = IDLE;
                        end
                    end
                end
                default: state_d[o] = IDLE;
            endcase
        end
    end

    // Outputs are held quiet for the whole time reset is asserted.
    always_comb begin
        grant = n_rst ? gnt_any : '0;
        for (int o = 0; o < NUM_OUTPORTS; o++) begin
            xbar_valid[o] = n_rst && out_valid[o];
            xbar_sel[o]   = n_rst ? out_sel[o] : '0;
            for (int v = 0; v < NUM_VCS; v++) begin
                packet_sent[o][v] = n_rst && out_valid[o] && (int'(out_vc[o]) == v);
            end
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int o = 0; o < NUM_OUTPORTS; o++) begin
                state_q[o]    <= IDLE;
                owner_q[o]    <= '0;
                owner_vc_q[o] <= '0;
                rr_ptr_q[o]   <= '0;
            end
        end else begin
            // NOTE: state registers use non-blocking assignments so every
            // output's update sees the same pre-edge values.
            for (int o = 0; o < NUM_OUTPORTS; o++) begin
                state_q[o]    <= state_d[o];
                owner_q[o]    <= owner_d[o];
                owner_vc_q[o] <= owner_vc_d[o];
                rr_ptr_q[o]   <= rr_ptr_d[o];
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: fairness, wormhole lock, credit stall,
// parallel outputs, mid-packet reset and out-of-range targets.
module tb_switch_allocator;

    localparam int NI = 4;
    localparam int NO = 3;  // 3 outputs so a 2-bit req_outport can name an invalid port
    localparam int NV = 2;
    localparam int IW = 2;
    localparam int OW = 2;
    localparam int VW = 1;

    logic                   clk;
    logic                   n_rst;
    logic [NI-1:0]          req;
    logic [NI-1:0][OW-1:0]  req_outport;
    logic [NI-1:0][VW-1:0]  req_vc;
    logic [NI-1:0]          req_tail;
    logic [NO-1:0][NV-1:0]  buffer_available;
    logic [NI-1:0]          grant;
    logic [NO-1:0]          xbar_valid;
    logic [NO-1:0][IW-1:0]  xbar_sel;
    logic [NO-1:0][NV-1:0]  packet_sent;

    int checks   = 0;
    int failures = 0;

    switch_allocator #(
        .NUM_INPORTS  (NI),
        .NUM_OUTPORTS (NO),
        .NUM_VCS      (NV)
    ) dut (
        .clk              (clk),
        .n_rst            (n_rst),
        .req              (req),
        .req_outport      (req_outport),
        .req_vc           (req_vc),
        .req_tail         (req_tail),
        .buffer_available (buffer_available),
        .grant            (grant),
        .xbar_valid       (xbar_valid),
        .xbar_sel         (xbar_sel),
        .packet_sent      (packet_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int i, input logic r, input int op, input int vc, input logic tail);
        req[i]         = r;
        req_outport[i] = OW'(op);
        req_vc[i]      = VW'(vc);
        req_tail[i]    = tail;
    endtask

    task automatic clear_reqs();
        req         = '0;
        req_outport = '0;
        req_vc      = '0;
        req_tail    = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_outs(input string tag, input logic [NI-1:0] g, input logic [NO-1:0] xv,
                              input logic [NO*NV-1:0] ps);
        check({tag, ".grant"},       32'(grant),       32'(g));
        check({tag, ".xbar_valid"},  32'(xbar_valid),  32'(xv));
        check({tag, ".packet_sent"}, 32'(packet_sent), 32'(ps));
    endtask

    initial begin
        n_rst            = 1'b0;
        buffer_available = '1;
        clear_reqs();
        for (int i = 0; i < NI; i++) set_req(i, 1'b1, 0, 0, 1'b1);

        // Reset state: all requesting, yet nothing may be granted.
        settle();
        check_outs("reset", 4'b0000, 3'b000, 6'b000000);
        check("reset.xbar_sel", 32'(xbar_sel), 32'd0);
        tick();
        tick();
        n_rst = 1'b1;
        clear_reqs();

        // Round-robin fairness at output 1, single-flit packets, VC = i%2.
        for (int i = 0; i < NI; i++) set_req(i, 1'b1, 1, i % 2, 1'b1);
        for (int k = 0; k < 5; k++) begin
            int w;
            w = k % 4;
            settle();
            check_outs($sformatf("rr%0d", k), 4'(1 << w), 3'b010, 6'(1 << (NV + (w % 2))));
            check($sformatf("rr%0d.sel", k), 32'(xbar_sel[1]), 32'(w));
            tick();
        end
        clear_reqs();

        // Wormhole lock: 3-flit packet from input 2 on out 0 / VC 1, input 3 waiting.
        set_req(2, 1'b1, 0, 1, 1'b0);
        set_req(3, 1'b1, 0, 0, 1'b1);
        for (int f = 0; f < 3; f++) begin
            req_tail[2] = (f == 2);
            req_vc[2]   = (f == 1) ? 1'b0 : 1'b1;  // owner VC field ignored while locked
            settle();
            check_outs($sformatf("worm%0d", f), 4'b0100, 3'b001, 6'b000010);
            check($sformatf("worm%0d.sel", f), 32'(xbar_sel[0]), 32'd2);
            tick();
        end
        req[2] = 1'b0;
        settle();
        check_outs("worm_next", 4'b1000, 3'b001, 6'b000001);
        check("worm_next.sel", 32'(xbar_sel[0]), 32'd3);
        tick();
        clear_reqs();

        // Credit stall and owner dropout mid-packet; input 3 stays blocked.
        set_req(2, 1'b1, 0, 1, 1'b0);
        set_req(3, 1'b1, 0, 0, 1'b1);
        settle();
        check_outs("stall_head", 4'b0100, 3'b001, 6'b000010);
        tick();
        buffer_available[0][1] = 1'b0;
        for (int c = 0; c < 2; c++) begin
            settle();
            check_outs($sformatf("stall%0d", c), 4'b0000, 3'b000, 6'b000000);
            tick();
        end
        buffer_available[0][1] = 1'b1;
        req[2] = 1'b0;
        settle();
        check_outs("owner_idle", 4'b0000, 3'b000, 6'b000000);
        tick();
        req[2]      = 1'b1;
        req_tail[2] = 1'b1;
        settle();
        check_outs("stall_tail", 4'b0100, 3'b001, 6'b000010);
        tick();
        req[2] = 1'b0;
        settle();
        check_outs("stall_next", 4'b1000, 3'b001, 6'b000001);
        tick();
        clear_reqs();

        // Parallel outputs in one cycle.
        set_req(0, 1'b1, 0, 0, 1'b1);
        set_req(1, 1'b1, 1, 1, 1'b1);
        settle();
        check_outs("par", 4'b0011, 3'b011, 6'b001001);
        check("par.sel0", 32'(xbar_sel[0]), 32'd0);
        check("par.sel1", 32'(xbar_sel[1]), 32'd1);
        tick();
        clear_reqs();

        // Reset in the middle of a 4-flit packet owned by input 2.
        set_req(2, 1'b1, 0, 0, 1'b0);
        for (int f = 0; f < 2; f++) begin
            settle();
            check_outs($sformatf("rst_pkt%0d", f), 4'b0100, 3'b001, 6'b000001);
            tick();
        end
        n_rst = 1'b0;
        set_req(3, 1'b1, 0, 0, 1'b1);
        settle();
        check_outs("rst_mid", 4'b0000, 3'b000, 6'b000000);
        check("rst_mid.sel", 32'(xbar_sel), 32'd0);
        tick();
        n_rst  = 1'b1;
        req[2] = 1'b0;
        set_req(1, 1'b1, 0, 0, 1'b1);
        settle();
        check_outs("rst_after", 4'b0010, 3'b001, 6'b000001);
        check("rst_after.sel", 32'(xbar_sel[0]), 32'd1);
        tick();
        clear_reqs();

        // Out-of-range target on input 0.
        set_req(0, 1'b1, NO, 0, 1'b1);
        settle();
        check_outs("bad_only", 4'b0000, 3'b000, 6'b000000);
        tick();
        set_req(1, 1'b1, 2, 1, 1'b1);
        settle();
        check_outs("bad_mix", 4'b0010, 3'b100, 6'b100000);
        check("bad_mix.sel2", 32'(xbar_sel[2]), 32'd1);
        tick();
        clear_reqs();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
